// File: rtl/pps_div_regbank.sv
// Double-buffered configuration register bank for N_CH PPS divider channels.
// Bus writes land in shadows; a per-channel commit FSM copies them to the actives.
module pps_div_regbank #(
    parameter int unsigned           N_CH       = 4,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           CH_STRIDE  = 16
) (
    input  logic                           i_clk_10,
    input  logic                           i_rst,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic                           i_wr,
    input  logic                           i_rd,
    input  logic                           i_pps,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_rd_valid,
    output logic [N_CH*DATA_WIDTH-1:0]     o_periodic_true,
    output logic [N_CH*DATA_WIDTH-1:0]     o_div_number,
    output logic [N_CH*4*DATA_WIDTH-1:0]   o_phase_us,
    output logic [N_CH*DATA_WIDTH-1:0]     o_width_us,
    output logic [N_CH*DATA_WIDTH-1:0]     o_start,
    output logic [N_CH*DATA_WIDTH-1:0]     o_stop,
    output logic [N_CH-1:0]                o_update
);

    localparam int unsigned SW        = $clog2(CH_STRIDE);
    localparam int unsigned NREG      = 9;
    localparam int unsigned RegCtrl   = 9;
    localparam int unsigned RegStatus = 10;

    typedef enum logic {StIdle, StPending} state_e;

    logic [N_CH-1:0][NREG-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [N_CH-1:0][NREG-1:0][DATA_WIDTH-1:0] active_q, active_d;
    state_e                                    state_q [N_CH];
    state_e                                    state_d [N_CH];
    logic [N_CH-1:0]                           loaded_q, loaded_d;
    logic [N_CH-1:0]                           update_q, update_d;
    logic [DATA_WIDTH-1:0]                     data_q, data_d;
    logic                                      rd_valid_q, rd_valid_d;

    logic [ADDR_WIDTH:0]    diff;
    logic [ADDR_WIDTH-SW-1:0] off_ch;
    logic [SW-1:0]          reg_off;
    logic                   mapped;
    logic [N_CH-1:0]        ch_wr;
    logic [N_CH-1:0]        copy;
    logic [DATA_WIDTH-1:0]  rd_val;

    // Extra MSB of the subtraction acts as the below-base borrow flag.
    always_comb begin
        diff    = {1'b0, i_addr} - {1'b0, BASE_ADDR};
        off_ch  = diff[ADDR_WIDTH-1:SW];
        reg_off = diff[SW-1:0];
        mapped  = !diff[ADDR_WIDTH] && (int'(off_ch) < N_CH);
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        loaded_d = loaded_q;
        update_d = '0;
        ch_wr    = '0;
        copy     = '0;
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
        end
        for (int c = 0; c < N_CH; c++) begin
            ch_wr[c] = i_wr && mapped && (int'(off_ch) == c);
            if (ch_wr[c] && (reg_off == SW'(RegCtrl)) && (i_data[2:0] != 3'b000)) begin
                if (i_data[2]) begin
                    state_d[c] = StIdle;
                end else if (i_data[1]) begin
                    copy[c]    = 1'b1;
                    state_d[c] = StIdle;
                end else if (state_q[c] == StIdle) begin
                    state_d[c] = StPending;
                end else if (i_pps) begin
                    copy[c]    = 1'b1;
                    state_d[c] = StIdle;
                end
            end else if ((state_q[c] == StPending) && i_pps) begin
                copy[c]    = 1'b1;
                state_d[c] = StIdle;
            end
            // Copy uses start-of-cycle shadows, so a same-cycle write is excluded.
            if (copy[c]) begin
                active_d[c] = shadow_q[c];
                loaded_d[c] = 1'b1;
                update_d[c] = 1'b1;
            end
            for (int r = 0; r < NREG; r++) begin
                if (ch_wr[c] && (reg_off == SW'(r))) begin
                    shadow_d[c][r] = i_data;
                end
            end
        end
    end

    always_comb begin
        data_d     = data_q;
        rd_valid_d = 1'b0;
        rd_val     = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (mapped && (int'(off_ch) == c)) begin
                for (int r = 0; r < NREG; r++) begin
                    if (reg_off == SW'(r)) begin
                        rd_val = shadow_q[c][r];
                    end
                end
                if (reg_off == SW'(RegStatus)) begin
                    rd_val = DATA_WIDTH'({loaded_q[c], state_q[c] == StPending});
                end
            end
        end
        // A simultaneous write wins; the read is dropped.
        if (i_rd && !i_wr) begin
            rd_valid_d = 1'b1;
            data_d     = rd_val;
        end
    end

    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            shadow_q   <= '0;
            active_q   <= '0;
            loaded_q   <= '0;
            update_q   <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= StIdle;
            end
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            loaded_q   <= loaded_d;
            update_q   <= update_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
            end
        end
    end

    always_comb begin
        o_periodic_true = '0;
        o_div_number    = '0;
        o_phase_us      = '0;
        o_width_us      = '0;
        o_start         = '0;
        o_stop          = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_periodic_true[c*DATA_WIDTH +: DATA_WIDTH] = active_q[c][0];
            o_div_number[c*DATA_WIDTH +: DATA_WIDTH]    = active_q[c][1];
            o_phase_us[c*4*DATA_WIDTH +: 4*DATA_WIDTH]  =
                {active_q[c][5], active_q[c][4], active_q[c][3], active_q[c][2]};
            o_width_us[c*DATA_WIDTH +: DATA_WIDTH]      = active_q[c][6];
            o_start[c*DATA_WIDTH +: DATA_WIDTH]         = active_q[c][7];
            o_stop[c*DATA_WIDTH +: DATA_WIDTH]          = active_q[c][8];
        end
    end

    assign o_data     = data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_update   = update_q;

endmodule
